// File: rtl/perf_counter_reporter_if.sv
// Byte stream link from the counter reporter toward the host-link transmitter.
interface perf_counter_reporter_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport master (output tx_data, output tx_valid, input tx_ready);
   modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/perf_counter_reporter.sv
// Snapshots the four datapath performance counters on a rising edge of
// finish and streams them as a 14-byte frame:
//   HEADER, stall[3], arith[3], mem[3], cpi[3], xor-checksum of bytes 1..12.
// Each counter is sent little-endian in 3 bytes, so CNT_W must be 17..24.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no frame in progress; waiting for a finish rising edge
// SEND  | presenting snapshot bytes idx 0..13 under valid/ready
module perf_counter_reporter #(
   parameter int          CNT_W  = 19,
   parameter logic [7:0]  HEADER = 8'hA5
) (
   input  logic             clkFPGA,
   input  logic             rst,
   input  logic             finish,
   input  logic [CNT_W-1:0] stall_count,
   input  logic [CNT_W-1:0] arith_count,
   input  logic [CNT_W-1:0] mem_count,
   input  logic [CNT_W-1:0] cpi_count,
   perf_counter_reporter_if.master tx,
   output logic             busy,
   output logic             frame_done,
   output logic             overrun
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] SEND = 1'b1;

   logic [0:0]       state;
   logic [3:0]       idx;
   logic [7:0]       csum;
   logic             finish_q;
   logic [CNT_W-1:0] snap_stall, snap_arith, snap_mem, snap_cpi;
   logic [23:0]      w_stall, w_arith, w_mem, w_cpi;
   logic [7:0]       sel_byte;
   logic             rise;
   logic             xfer;

   assign rise = finish & ~finish_q;
   assign xfer = (state == SEND) & tx.tx_ready;

   // Zero-extend each snapshot to 24 bits so the top byte is well defined.
   always_comb begin
      w_stall = '0;
      w_arith = '0;
      w_mem   = '0;
      w_cpi   = '0;
      w_stall[CNT_W-1:0] = snap_stall;
      w_arith[CNT_W-1:0] = snap_arith;
      w_mem[CNT_W-1:0]   = snap_mem;
      w_cpi[CNT_W-1:0]   = snap_cpi;
   end

   // Frame byte selected by idx; only the snapshot feeds the stream.
   always_comb begin
      sel_byte = 8'h00;
      case (idx)
         4'd0:  sel_byte = HEADER;
         4'd1:  sel_byte = w_stall[7:0];
         4'd2:  sel_byte = w_stall[15:8];
         4'd3:  sel_byte = w_stall[23:16];
         4'd4:  sel_byte = w_arith[7:0];
         4'd5:  sel_byte = w_arith[15:8];
         4'd6:  sel_byte = w_arith[23:16];
         4'd7:  sel_byte = w_mem[7:0];
         4'd8:  sel_byte = w_mem[15:8];
         4'd9:  sel_byte = w_mem[23:16];
         4'd10: sel_byte = w_cpi[7:0];
         4'd11: sel_byte = w_cpi[15:8];
         4'd12: sel_byte = w_cpi[23:16];
         4'd13: sel_byte = csum;
         default: sel_byte = 8'h00;
      endcase
   end

   // Outputs are pure decodes of the state so valid never glitches mid-frame.
   always_comb begin
      tx.tx_valid = (state == SEND);
      tx.tx_data  = (state == SEND) ? sel_byte : 8'h00;
      busy        = (state == SEND);
   end

   // Frame sequencing, snapshot capture, checksum and overrun tracking.
   always_ff @(posedge clkFPGA) begin
      if (rst) begin
         state      <= IDLE;
         idx        <= '0;
         csum       <= '0;
         finish_q   <= 1'b0;
         frame_done <= 1'b0;
         overrun    <= 1'b0;
         snap_stall <= '0;
         snap_arith <= '0;
         snap_mem   <= '0;
         snap_cpi   <= '0;
      end else begin
         finish_q   <= finish;
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               if (rise) begin
                  snap_stall <= stall_count;
                  snap_arith <= arith_count;
                  snap_mem   <= mem_count;
                  snap_cpi   <= cpi_count;
                  idx        <= '0;
                  csum       <= '0;
                  state      <= SEND;
               end
            end
            SEND: begin
               // A second trigger mid-frame is flagged, never queued.
               if (rise) overrun <= 1'b1;
               if (xfer) begin
                  if (idx != 4'd0 && idx != 4'd13) csum <= csum ^ sel_byte;
                  if (idx == 4'd13) begin
                     idx        <= '0;
                     state      <= IDLE;
                     frame_done <= 1'b1;
                  end else begin
                     idx <= idx + 4'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_perf_counter_reporter.sv
// Directed bench for perf_counter_reporter: frame content, backpressure,
// snapshot isolation, overrun, level finish, back-to-back, reset abort.
module tb_perf_counter_reporter;

   logic        clk;
   logic        rst;
   logic        finish;
   logic [18:0] stall_count, arith_count, mem_count, cpi_count;
   logic        busy, frame_done, overrun;

   perf_counter_reporter_if tx_if ();

   perf_counter_reporter #(.CNT_W(19), .HEADER(8'hA5)) dut (
      .clkFPGA     (clk),
      .rst         (rst),
      .finish      (finish),
      .stall_count (stall_count),
      .arith_count (arith_count),
      .mem_count   (mem_count),
      .cpi_count   (cpi_count),
      .tx          (tx_if),
      .busy        (busy),
      .frame_done  (frame_done),
      .overrun     (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic [7:0] exp_basic [14] = '{8'hA5, 8'h45, 8'h23, 8'h01, 8'hFF, 8'hFF, 8'h07,
                                  8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h65};
   logic [7:0] exp_zero  [14] = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                                  8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
   logic [7:0] cur [14];

   int stall_a_idx = -1, stall_a_len = 0;
   int stall_b_idx = -1, stall_b_len = 0;
   int pulse_at    = -1;
   bit mutate      = 0;
   bit raise_at_done = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_basic();
      stall_count = 19'h12345;
      arith_count = 19'h7FFFF;
      mem_count   = 19'h00000;
      cpi_count   = 19'h00005;
   endtask

   // Pulse finish for one cycle; returns at the negedge where byte 0 is shown.
   task automatic trigger();
      finish = 1'b1;
      @(negedge clk);
      finish = 1'b0;
   endtask

   task automatic hold_byte(input string tag, input int i);
      chk({tag, "_stall_valid"}, {31'd0, tx_if.tx_valid}, 32'd1);
      chk({tag, "_stall_data"},  {24'd0, tx_if.tx_data},  {24'd0, cur[i]});
   endtask

   // Expects to be entered at the negedge where byte 0 is presented.
   task automatic recv_frame(input string tag);
      for (int i = 0; i < 14; i++) begin
         if (i == stall_a_idx || i == stall_b_idx) begin
            tx_if.tx_ready = 1'b0;
            for (int k = 0; k < ((i == stall_a_idx) ? stall_a_len : stall_b_len); k++) begin
               if (mutate) begin
                  stall_count = 19'h0AAAA; arith_count = 19'h0AAAA;
                  mem_count   = 19'h0AAAA; cpi_count   = 19'h0AAAA;
               end
               hold_byte(tag, i);
               @(negedge clk);
            end
         end
         tx_if.tx_ready = 1'b1;
         if (mutate) begin
            stall_count = 19'h0AAAA; arith_count = 19'h0AAAA;
            mem_count   = 19'h0AAAA; cpi_count   = 19'h0AAAA;
         end
         if (pulse_at >= 0 && i == pulse_at)     finish = 1'b1;
         if (pulse_at >= 0 && i == pulse_at + 1) finish = 1'b0;
         chk({tag, "_valid"}, {31'd0, tx_if.tx_valid}, 32'd1);
         chk({tag, "_busy"},  {31'd0, busy},           32'd1);
         chk({tag, "_data"},  {24'd0, tx_if.tx_data},  {24'd0, cur[i]});
         chk({tag, "_done_early"}, {31'd0, frame_done}, 32'd0);
         @(negedge clk);
      end
      chk({tag, "_frame_done"}, {31'd0, frame_done},     32'd1);
      chk({tag, "_end_valid"},  {31'd0, tx_if.tx_valid}, 32'd0);
      chk({tag, "_end_busy"},   {31'd0, busy},           32'd0);
      if (raise_at_done) finish = 1'b1;
      @(negedge clk);
      chk({tag, "_done_pulse"}, {31'd0, frame_done}, 32'd0);
   endtask

   initial begin
      rst = 1'b1; finish = 1'b0; tx_if.tx_ready = 1'b1;
      set_basic();
      repeat (2) @(negedge clk);
      chk("rst_valid", {31'd0, tx_if.tx_valid}, 32'd0);
      chk("rst_data",  {24'd0, tx_if.tx_data},  32'd0);
      chk("rst_busy",  {31'd0, busy},           32'd0);
      chk("rst_done",  {31'd0, frame_done},     32'd0);
      chk("rst_ovr",   {31'd0, overrun},        32'd0);
      rst = 1'b0;
      @(negedge clk);

      // tx_ready ignored while idle
      tx_if.tx_ready = 1'b1;
      @(negedge clk);
      chk("idle_valid", {31'd0, tx_if.tx_valid}, 32'd0);

      // 1: basic frame
      cur = exp_basic;
      trigger();
      recv_frame("basic");
      @(negedge clk);

      // 2: backpressure
      stall_a_idx = 0; stall_a_len = 3;
      stall_b_idx = 7; stall_b_len = 5;
      trigger();
      recv_frame("bp");
      stall_a_idx = -1; stall_b_idx = -1;
      @(negedge clk);
      chk("bp_no_ovr", {31'd0, overrun}, 32'd0);

      // 3: snapshot isolation and overrun
      trigger();
      mutate = 1; pulse_at = 4;
      recv_frame("iso");
      mutate = 0; pulse_at = -1;
      for (int k = 0; k < 6; k++) begin
         chk("iso_no_second", {31'd0, tx_if.tx_valid}, 32'd0);
         chk("iso_ovr_sticky", {31'd0, overrun}, 32'd1);
         @(negedge clk);
      end

      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst2_ovr", {31'd0, overrun}, 32'd0);
      set_basic();
      @(negedge clk);

      // 4: level finish gives one frame, then back-to-back at frame_done
      finish = 1'b1;
      @(negedge clk);
      recv_frame("level");
      for (int k = 0; k < 24; k++) begin
         chk("level_no_retrig", {31'd0, tx_if.tx_valid}, 32'd0);
         @(negedge clk);
      end
      finish = 1'b0;
      @(negedge clk);
      trigger();
      raise_at_done = 1;
      recv_frame("b2b_a");
      raise_at_done = 0;
      finish = 1'b0;
      recv_frame("b2b_b");
      chk("b2b_ovr", {31'd0, overrun}, 32'd0);
      @(negedge clk);

      // 5: reset mid-frame (overrun set first so its clearing is visible)
      trigger();
      for (int i = 0; i < 6; i++) begin
         finish = (i == 2);
         chk("abort_data", {24'd0, tx_if.tx_data}, {24'd0, cur[i]});
         @(negedge clk);
      end
      finish = 1'b0;
      chk("abort_idx6",    {24'd0, tx_if.tx_data}, 32'h07);
      chk("abort_ovr_set", {31'd0, overrun},       32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_valid", {31'd0, tx_if.tx_valid}, 32'd0);
      chk("abort_busy",  {31'd0, busy},           32'd0);
      chk("abort_ovr",   {31'd0, overrun},        32'd0);
      chk("abort_done",  {31'd0, frame_done},     32'd0);
      @(negedge clk);
      chk("abort_stays_idle", {31'd0, tx_if.tx_valid}, 32'd0);
      trigger();
      recv_frame("after_abort");
      @(negedge clk);

      // 6: all-zero counters
      stall_count = '0; arith_count = '0; mem_count = '0; cpi_count = '0;
      cur = exp_zero;
      trigger();
      recv_frame("zero");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/perf_counter_reporter.md
Name: perf_counter_reporter

Overview:
- Reads the four 19-bit performance counters exported by the pipelined datapath: stall count, arithmetic count, memory count and cycles-per-instruction.
- On a rising edge of the datapath's `finish` signal, takes an atomic snapshot of all four counters.
- Streams the snapshot as a framed byte sequence over a valid/ready byte interface toward the host-link transmitter.
- Sits beside the datapath at top level and is the consumer of its R28–R31 counter outputs.

Parameters:
- CNT_W, 19, counter width; must be 17..24 so each counter packs into exactly 3 bytes.
- HEADER, 8'hA5, first byte of every frame.

Ports:
- clkFPGA  input  1  single system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- finish  input  1  datapath finished flag (level); a frame is triggered on its rising edge.
- stall_count  input  CNT_W  live R28 stall counter.
- arith_count  input  CNT_W  live R29 arithmetic-instruction counter.
- mem_count  input  CNT_W  live R30 memory-instruction counter.
- cpi_count  input  CNT_W  live R31 cycles-per-instruction value.
- tx_data  output  8  current frame byte.
- tx_valid  output  1  tx_data holds a byte awaiting acceptance.
- tx_ready  input  1  sink accepts the byte at this edge when tx_valid is also high.
- busy  output  1  a frame is in progress (snapshot taken, last byte not yet accepted).
- frame_done  output  1  one-cycle pulse after the final byte is accepted.
- overrun  output  1  sticky; set when a finish rising edge arrives while busy; cleared only by rst.

Behaviour:
- Reset (rst high at an edge):
  - Outputs become tx_valid=0, tx_data=0, busy=0, frame_done=0, overrun=0.
  - Snapshot registers, byte index, checksum and finish_q (previous-cycle finish) are cleared.
  - State becomes IDLE.
  - A reset mid-frame aborts the frame; no further bytes are presented.
- Trigger: rise = finish & ~finish_q, evaluated every cycle; finish_q is a register updated every cycle.
- States: IDLE, SEND.
- IDLE:
  - tx_valid=0, busy=0.
  - On rise, the edge loads all four counters into snapshot registers, sets idx=0, clears the checksum and moves to SEND.
  - Latency: rise seen in cycle N gives tx_valid=1 with tx_data=HEADER in cycle N+1.
- SEND:
  - tx_valid=1, busy=1.
  - tx_data is selected by idx from the snapshot registers, never from the live counters.
- Frame layout is 14 bytes, idx 0..13:
  - idx 0: HEADER.
  - idx 1–3: stall, little-endian; byte 3 = zero-extended bits [CNT_W-1:16].
  - idx 4–6: arith, same packing.
  - idx 7–9: mem, same packing.
  - idx 10–12: cpi, same packing.
  - idx 13: checksum, the XOR of bytes 1–12 (HEADER excluded).
- Handshake:
  - A byte transfers at an edge where tx_valid & tx_ready; idx then increments.
  - A data byte also XORs into the checksum on transfer.
  - While tx_ready=0, tx_data and tx_valid stay stable; tx_valid never drops mid-frame.
  - tx_ready is ignored in IDLE.
- End of frame:
  - When byte 13 transfers, the next cycle is IDLE with tx_valid=0, busy=0 and frame_done=1 for exactly one cycle.
  - A rise in that same cycle is accepted normally (back-to-back frames allowed).
- Overrun:
  - A rise while in SEND sets overrun and is otherwise ignored; it does not queue a frame.
  - Holding finish high past frame end does not retrigger; a new frame needs finish to go low, then high.
- Snapshot isolation: live counter changes after the snapshot edge never alter the frame in flight.
- Throughput: with tx_ready held high, the 14 bytes occupy 14 consecutive cycles.

Test Plan:
1. Basic frame:
   - Stimulus: rst pulse; stall=19'h12345, arith=19'h7FFFF, mem=0, cpi=19'h00005; pulse finish with tx_ready=1.
   - Response: bytes A5 45 23 01 FF FF 07 00 00 00 05 00 00 65 in 14 consecutive cycles, first byte one cycle after the rise.
   - Response: frame_done high in exactly the following cycle, low after.
2. Backpressure:
   - Stimulus: same as 1, with tx_ready held low 3 cycles at idx 0 and 5 cycles at idx 7.
   - Response: identical byte sequence; tx_data stable and tx_valid high throughout the stalls; frame_done after byte 65.
3. Snapshot isolation and overrun:
   - Stimulus: after the trigger, change all counters to 19'h0AAAA each cycle and pulse finish again at idx 4.
   - Response: frame still carries the scenario-1 values; overrun=1 and stays 1; no second frame follows.
4. Level finish and back-to-back:
   - Stimulus: hold finish high for 40 cycles.
   - Response: exactly one frame.
   - Stimulus: drop finish, then raise it in the frame_done cycle.
   - Response: a second frame starts next cycle with A5.
5. Reset mid-frame:
   - Stimulus: assert rst at idx 6.
   - Response: next cycle tx_valid=0, busy=0, overrun=0, frame_done=0.
   - Response: a later finish rise produces a complete, correct 14-byte frame starting with A5.
6. All-zero counters:
   - Stimulus: all four counters = 0.
   - Response: A5 followed by twelve 00 bytes, checksum 00.
